// File: rtl/control_unit_ext.sv
// control_unit_ext: PC + IDLE/RUN/WAIT/HALT sequencer and instruction decoder for the accumulator CPU.
// Latency: strobes are combinational from i_Data/state; RAM reads take one extra (WAIT) cycle when MEM_LAT=1.
// Backpressure: i_en=0 freezes state/PC and forces strobes low; HALT holds until reset.
// Ports: i_clk/i_rst (async active-low) clock and reset; i_en run enable; i_Data instruction at o_PC;
//        i_acc_zero/i_acc_neg branch flags; o_PC program address; o_Data sign-extended operand;
//        o_Addr RAM address; sel_A/sel_B/o_op datapath selects; w_acc/w_ram/r_ram strobes;
//        o_halt in HALT; o_illegal sticky undefined-opcode flag.
module control_unit_ext #(
   parameter int BITS    = 16,
   parameter int OPBITS  = 5,
   parameter int PCBITS  = 11,
   parameter int MEM_LAT = 0
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_en,
   input  logic [BITS-1:0]          i_Data,
   input  logic                     i_acc_zero,
   input  logic                     i_acc_neg,
   output logic [PCBITS-1:0]        o_PC,
   output logic [BITS-1:0]          o_Data,
   output logic [BITS-OPBITS-1:0]   o_Addr,
   output logic [1:0]               sel_A,
   output logic                     sel_B,
   output logic [2:0]               o_op,
   output logic                     w_acc,
   output logic                     w_ram,
   output logic                     r_ram,
   output logic                     o_halt,
   output logic                     o_illegal
);
   localparam int DTBITS = BITS - OPBITS;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT, S_HALT} state_t;

   state_t              state_q, state_nx;
   logic [PCBITS-1:0]   pc_q, pc_nx;
   logic                ill_q, ill_nx;

   logic [OPBITS-1:0]   opcode;
   logic [DTBITS-1:0]   operand;
   int                  opc;

   logic                dec_wacc, dec_wram, dec_rram, dec_selb;
   logic                dec_take, dec_hlt, dec_ill;
   logic [1:0]          dec_sela;
   logic [2:0]          dec_op;

   assign opcode  = i_Data[BITS-1 -: OPBITS];
   assign operand = i_Data[DTBITS-1:0];
   assign opc     = int'(opcode);

   assign o_Data    = {{OPBITS{operand[DTBITS-1]}}, operand};
   assign o_Addr    = operand;
   assign o_PC      = pc_q;
   assign o_halt    = (state_q == S_HALT);
   assign o_illegal = ill_q;

   // Pure instruction decode, independent of state.
   always_comb begin
      dec_wacc = 1'b0;
      dec_wram = 1'b0;
      dec_rram = 1'b0;
      dec_selb = 1'b0;
      dec_sela = 2'd0;
      dec_op   = 3'd0;
      dec_take = 1'b0;
      dec_hlt  = 1'b0;
      dec_ill  = 1'b0;
      case (opc)
         'h00: dec_hlt = 1'b1;
         'h01: dec_wram = 1'b1;
         'h02: begin dec_rram = 1'b1; dec_wacc = 1'b1; end
         'h03: begin dec_wacc = 1'b1; dec_sela = 2'd1; end
         // Paired ALU ops: even opcode = RAM operand, odd = immediate; pair index is the ALU op.
         'h04, 'h05, 'h06, 'h07, 'h08, 'h09, 'h0A, 'h0B, 'h0C, 'h0D: begin
            dec_wacc = 1'b1;
            dec_sela = 2'd2;
            dec_op   = 3'((opc - 4) >> 1);
            if (opc[0]) dec_selb = 1'b1;
            else        dec_rram = 1'b1;
         end
         'h0E: begin dec_wacc = 1'b1; dec_sela = 2'd2; dec_selb = 1'b1; dec_op = 3'd5; end
         'h0F: begin dec_wacc = 1'b1; dec_sela = 2'd2; dec_selb = 1'b1; dec_op = 3'd6; end
         'h10: dec_take = 1'b1;
         'h11: dec_take = i_acc_zero;
         'h12: dec_take = !i_acc_zero;
         'h13: dec_take = i_acc_neg;
         'h14: ;
         default: dec_ill = 1'b1;
      endcase
   end

   // Sequencing: strobes only leave zero in RUN/WAIT with i_en high.
   always_comb begin
      state_nx = state_q;
      pc_nx    = pc_q;
      ill_nx   = ill_q;
      w_acc    = 1'b0;
      w_ram    = 1'b0;
      r_ram    = 1'b0;
      sel_A    = 2'd0;
      sel_B    = 1'b0;
      o_op     = 3'd0;
      case (state_q)
         S_IDLE: if (i_en) state_nx = S_RUN;
         S_RUN: if (i_en) begin
            if (dec_hlt) begin
               state_nx = S_HALT;
            end else if (MEM_LAT == 1 && dec_rram) begin
               // First half of a slow read: address the RAM, hold PC so i_Data stays put.
               r_ram    = 1'b1;
               sel_A    = dec_sela;
               sel_B    = dec_selb;
               o_op     = dec_op;
               state_nx = S_WAIT;
            end else begin
               w_acc  = dec_wacc;
               w_ram  = dec_wram;
               r_ram  = dec_rram;
               if (dec_wacc || dec_wram || dec_rram) begin
                  sel_A = dec_sela;
                  sel_B = dec_selb;
                  o_op  = dec_op;
               end
               pc_nx  = dec_take ? operand[PCBITS-1:0] : pc_q + PCBITS'(1);
               if (dec_ill) ill_nx = 1'b1;
            end
         end
         S_WAIT: if (i_en) begin
            w_acc    = dec_wacc;
            r_ram    = dec_rram;
            sel_A    = dec_sela;
            sel_B    = dec_selb;
            o_op     = dec_op;
            pc_nx    = pc_q + PCBITS'(1);
            state_nx = S_RUN;
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q <= S_IDLE;
         pc_q    <= '0;
         ill_q   <= 1'b0;
      end else begin
         state_q <= state_nx;
         pc_q    <= pc_nx;
         ill_q   <= ill_nx;
      end
   end
endmodule
